// File: rtl/store_pkg.sv
// Shared definitions for the store lane unit: FSM state encoding and the
// funct3 store-size codes. BEAT1 only exists when STORE_MISALIGNED_SPLIT_EN
// is defined (misaligned stores are split into two bus beats).
package store_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
`ifdef STORE_MISALIGNED_SPLIT_EN
        BEAT1 = 2'd2,
`endif
        BEAT0 = 2'd1
    } state_e;

    localparam logic [2:0] SB = 3'b000;
    localparam logic [2:0] SH = 3'b001;
    localparam logic [2:0] SW = 3'b010;
    localparam logic [2:0] SD = 3'b011;

    // Number of bytes written by a store of the given funct3 size code.
    function automatic logic [3:0] size_bytes(input logic [2:0] f3);
        case (f3)
            SB:      size_bytes = 4'd1;
            SH:      size_bytes = 4'd2;
            SW:      size_bytes = 4'd4;
            SD:      size_bytes = 4'd8;
            default: size_bytes = 4'd1;
        endcase
    endfunction

endpackage

// File: rtl/store_lane_gen.sv
// Combinational lane generator: places a right-justified store into byte
// lanes of a double-width window starting at offset off_i, then returns the
// low half (first beat) or the high half (second beat of a split store).
module store_lane_gen #(
    parameter int XLEN = 32
) (
    input  logic [$clog2(XLEN/8)-1:0] off_i,
    input  logic [3:0]                sz_i,
    input  logic                      beat1_i,
    input  logic [XLEN-1:0]           wdata_i,
    output logic [XLEN/8-1:0]         be_o,
    output logic [XLEN-1:0]           wdata_o
);
    localparam int NB = XLEN / 8;

    logic [2*NB-1:0]   lanes2;
    logic [2*XLEN-1:0] data2;

    // Build lane mask and shifted data over two beats, then pick the half.
    always_comb begin
        lanes2 = '0;
        for (int i = 0; i < 2*NB; i++) begin
            lanes2[i] = (i >= int'(off_i)) && (i < int'(off_i) + int'(sz_i));
        end
        data2   = {{XLEN{1'b0}}, wdata_i} << (8 * off_i);
        be_o    = beat1_i ? lanes2[2*NB-1:NB]     : lanes2[NB-1:0];
        wdata_o = beat1_i ? data2[2*XLEN-1:XLEN]  : data2[XLEN-1:0];
    end

endmodule

// File: rtl/store_lane_unit.sv
// Store lane unit: accepts one store at a time, converts it into one (or,
// with STORE_MISALIGNED_SPLIT_EN defined, two) aligned bus beats with byte
// enables, and flags illegal sizes / unsplit misaligned stores with a pulse.
// Optional feature macro: STORE_MISALIGNED_SPLIT_EN.
module store_lane_unit
    import store_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              MemWriteM,
    input  logic [2:0]        funct3M,
    input  logic [XLEN-1:0]   addrM,
    input  logic [XLEN-1:0]   wdataM,
    output logic              stallM,
    output logic              mem_valid,
    input  logic              mem_ready,
    output logic [XLEN-1:0]   mem_addr,
    output logic [XLEN-1:0]   mem_wdata,
    output logic [XLEN/8-1:0] mem_be,
    output logic              misalignedM,
    output logic              illegalM
);
    localparam int NB   = XLEN / 8;
    localparam int OFFW = $clog2(NB);

    state_e            state_q, state_d;
    logic [XLEN-1:0]   base_q, base_d;
    logic [XLEN-1:0]   wdata_q, wdata_d;
    logic [OFFW-1:0]   off_q, off_d;
    logic [3:0]        sz_q, sz_d;

    logic [OFFW-1:0]   req_off;
    logic [3:0]        req_sz;
    logic              req_legal;
    logic              accept;
    logic              req_go;
    logic              beat1_sel;
    logic [NB-1:0]     gen_be;
    logic [XLEN-1:0]   gen_wdata;
`ifdef STORE_MISALIGNED_SPLIT_EN
    logic [4:0]        cur_end;
    logic              cur_split;
`else
    logic [4:0]        req_end;
    logic              req_mis;
`endif

    // Decode the incoming request and decide whether it becomes a bus store.
    always_comb begin
        req_off   = addrM[OFFW-1:0];
        req_sz    = size_bytes(funct3M);
        req_legal = !funct3M[2] && !((funct3M == SD) && (XLEN == 32));
        stallM    = (state_q != IDLE);
        accept    = MemWriteM && (state_q == IDLE);
        illegalM  = rst_n && accept && !req_legal;
`ifdef STORE_MISALIGNED_SPLIT_EN
        cur_end     = 5'(off_q) + 5'(sz_q);
        cur_split   = (cur_end > 5'(NB));
        req_go      = accept && req_legal;
        misalignedM = 1'b0;
`else
        req_end     = 5'(req_off) + 5'(req_sz);
        req_mis     = (req_end > 5'(NB));
        req_go      = accept && req_legal && !req_mis;
        misalignedM = rst_n && accept && req_legal && req_mis;
`endif
    end

    // Next-state logic and request capture.
    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        wdata_d = wdata_q;
        off_d   = off_q;
        sz_d    = sz_q;
        case (state_q)
            IDLE: begin
                if (req_go) begin
                    state_d = BEAT0;
                    base_d  = addrM & ~XLEN'(NB - 1);
                    wdata_d = wdataM;
                    off_d   = req_off;
                    sz_d    = req_sz;
                end
            end
            BEAT0: begin
                if (mem_ready) begin
`ifdef STORE_MISALIGNED_SPLIT_EN
                    state_d = cur_split ? BEAT1 : IDLE;
`else
                    state_d = IDLE;
`endif
                end
            end
`ifdef STORE_MISALIGNED_SPLIT_EN
            BEAT1: begin
                if (mem_ready) state_d = IDLE;
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    // FSM state register; reset abandons any store in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Captured request fields; only observed outside IDLE, so no reset.
    always_ff @(posedge clk) begin
        base_q  <= base_d;
        wdata_q <= wdata_d;
        off_q   <= off_d;
        sz_q    <= sz_d;
    end

`ifdef STORE_MISALIGNED_SPLIT_EN
    assign beat1_sel = (state_q == BEAT1);
`else
    assign beat1_sel = 1'b0;
`endif

    store_lane_gen #(.XLEN(XLEN)) u_lane_gen (
        .off_i   (off_q),
        .sz_i    (sz_q),
        .beat1_i (beat1_sel),
        .wdata_i (wdata_q),
        .be_o    (gen_be),
        .wdata_o (gen_wdata)
    );

    // Bus beat outputs, forced to zero whenever no beat is in progress.
    always_comb begin
        mem_valid = (state_q != IDLE);
        mem_addr  = '0;
        mem_be    = '0;
        mem_wdata = '0;
        if (mem_valid) begin
            mem_addr  = beat1_sel ? base_q + XLEN'(NB) : base_q;
            mem_be    = gen_be;
            mem_wdata = gen_wdata;
        end
    end

endmodule

// File: tb/tb_store_lane_unit.sv
// Testbench for store_lane_unit: a 32-bit and a 64-bit instance, directed
// and random stores checked against a byte-lane reference model.
module tb_store_lane_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        we32, we64;
    logic [2:0]  f3;
    logic [63:0] addr, wdata;
    logic        mem_ready;
    bit          use64;

    logic        stall32, valid32, mis32, ill32;
    logic [31:0] maddr32, mwd32;
    logic [3:0]  be32;
    logic        stall64, valid64, mis64, ill64;
    logic [63:0] maddr64, mwd64;
    logic [7:0]  be64;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    store_lane_unit #(.XLEN(32)) u_dut32 (
        .clk(clk), .rst_n(rst_n), .MemWriteM(we32), .funct3M(f3),
        .addrM(addr[31:0]), .wdataM(wdata[31:0]), .stallM(stall32),
        .mem_valid(valid32), .mem_ready(mem_ready), .mem_addr(maddr32),
        .mem_wdata(mwd32), .mem_be(be32), .misalignedM(mis32), .illegalM(ill32)
    );

    store_lane_unit #(.XLEN(64)) u_dut64 (
        .clk(clk), .rst_n(rst_n), .MemWriteM(we64), .funct3M(f3),
        .addrM(addr), .wdataM(wdata), .stallM(stall64),
        .mem_valid(valid64), .mem_ready(mem_ready), .mem_addr(maddr64),
        .mem_wdata(mwd64), .mem_be(be64), .misalignedM(mis64), .illegalM(ill64)
    );

    logic        o_stall, o_valid, o_mis, o_ill;
    logic [63:0] o_addr, o_wd, o_be;
    assign o_stall = use64 ? stall64 : stall32;
    assign o_valid = use64 ? valid64 : valid32;
    assign o_mis   = use64 ? mis64   : mis32;
    assign o_ill   = use64 ? ill64   : ill32;
    assign o_addr  = use64 ? maddr64 : {32'h0, maddr32};
    assign o_wd    = use64 ? mwd64   : {32'h0, mwd32};
    assign o_be    = use64 ? {56'h0, be64} : {60'h0, be32};

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference model: expected response of an XLEN = 8*nb unit to one store.
    task automatic model(input bit w64, input logic [2:0] fn, input logic [63:0] a,
                         input logic [63:0] d, output bit ill, output bit mis,
                         output int nbeats, output logic [63:0] a0, output logic [63:0] a1,
                         output logic [63:0] b0, output logic [63:0] b1,
                         output logic [63:0] w0, output logic [63:0] w1);
        int nb, sz, off, last;
        logic [63:0] m, dt;
        nb  = w64 ? 8 : 4;
        m   = w64 ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
        dt  = d & m;
        sz  = (fn == 3'd0) ? 1 : (fn == 3'd1) ? 2 : (fn == 3'd2) ? 4 : 8;
        ill = (fn > 3'd3) || (fn == 3'd3 && !w64);
        off = int'(a % 64'(nb));
        mis = !ill && (off + sz > nb);
        last = off + sz - 1;
        a0 = (a & m) - 64'(off);
        a1 = (a0 + 64'(nb)) & m;
        b0 = '0;
        b1 = '0;
        for (int l = 0; l < nb; l++) begin
            if (l >= off && l <= last) b0[l] = 1'b1;
            if (l <= last - nb)        b1[l] = 1'b1;
        end
        w0 = (dt << (8 * off)) & m;
        w1 = dt >> (8 * (nb - off));
        if (ill) nbeats = 0;
        else if (mis) begin
`ifdef STORE_MISALIGNED_SPLIT_EN
            nbeats = 2;
`else
            nbeats = 0;
`endif
        end else nbeats = 1;
    endtask

    // One complete store: acceptance, beats with ready back-pressure, idle.
    task automatic do_store(input bit w64, input logic [2:0] fn, input logic [63:0] a,
                            input logic [63:0] d, input int waits);
        bit ill, mis;
        int nbeats, w;
        logic [63:0] ea[2], eb[2], ew[2];
        model(w64, fn, a, d, ill, mis, nbeats, ea[0], ea[1], eb[0], eb[1], ew[0], ew[1]);
        @(negedge clk);
        use64 = w64;
        we32 = !w64;
        we64 = w64;
        f3 = fn;
        addr = a;
        wdata = d;
        mem_ready = 1'b0;
        #1;
        chk("accept_stall", {63'h0, o_stall}, 64'h0);
        chk("illegal_pulse", {63'h0, o_ill}, {63'h0, ill});
`ifdef STORE_MISALIGNED_SPLIT_EN
        chk("misaligned_pulse", {63'h0, o_mis}, 64'h0);
`else
        chk("misaligned_pulse", {63'h0, o_mis}, {63'h0, mis});
`endif
        @(negedge clk);
        we32 = 1'b0;
        we64 = 1'b0;
        f3 = 3'($urandom_range(0, 7));
        addr = {$urandom, $urandom};
        wdata = {$urandom, $urandom};
        for (int b = 0; b < nbeats; b++) begin
            w = (waits < 0) ? int'($urandom_range(0, 2)) : waits;
            for (int k = 0; k <= w; k++) begin
                chk("beat_valid", {63'h0, o_valid}, 64'h1);
                chk("beat_stall", {63'h0, o_stall}, 64'h1);
                chk("beat_addr", o_addr, ea[b]);
                chk("beat_be", o_be, eb[b]);
                chk("beat_wdata", o_wd, ew[b]);
                mem_ready = (k == w);
                @(negedge clk);
            end
        end
        mem_ready = 1'b0;
        chk("idle_valid", {63'h0, o_valid}, 64'h0);
        chk("idle_be", o_be, 64'h0);
        chk("idle_stall", {63'h0, o_stall}, 64'h0);
    endtask

    initial begin
        rst_n = 1'b1;
        use64 = 1'b0;
        we32 = 1'b0;
        we64 = 1'b0;
        f3 = 3'd0;
        addr = '0;
        wdata = '0;
        mem_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_stall", {63'h0, o_stall}, 64'h0);
        chk("rst_valid", {63'h0, o_valid}, 64'h0);
        chk("rst_be", o_be, 64'h0);
        chk("rst_addr", o_addr, 64'h0);
        chk("rst_wdata", o_wd, 64'h0);
        chk("rst_pulses", {62'h0, o_mis, o_ill}, 64'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed cases from the requirement examples.
        do_store(1'b0, 3'b000, 64'h1003, 64'hAB, 0);
        do_store(1'b0, 3'b001, 64'h1002, 64'h1234, 3);
        do_store(1'b0, 3'b010, 64'h1002, 64'hAABBCCDD, 1);
        do_store(1'b0, 3'b011, 64'h1000, 64'h1111_2222, 0);
        do_store(1'b0, 3'b110, 64'h1000, 64'h3333_4444, 0);
        do_store(1'b1, 3'b011, 64'h2000, 64'h0123_4567_89AB_CDEF, 0);
        do_store(1'b1, 3'b011, 64'h2003, 64'hFEDC_BA98_7654_3210, 1);
        do_store(1'b1, 3'b111, 64'h2000, 64'h1, 0);
        do_store(1'b0, 3'b010, 64'h1000, 64'hDEADBEEF, 2);

        // Random stores, mostly legal sizes.
        for (int n = 0; n < 40; n++)
            do_store(1'b0, 3'($urandom_range(0, 4)), {32'h0, $urandom}, {32'h0, $urandom}, -1);
        for (int n = 0; n < 25; n++)
            do_store(1'b1, 3'($urandom_range(0, 4)), {$urandom, $urandom}, {$urandom, $urandom}, -1);

        // Reset in the middle of a store abandons it.
        @(negedge clk);
        use64 = 1'b0;
        we32 = 1'b1;
        f3 = 3'b010;
`ifdef STORE_MISALIGNED_SPLIT_EN
        addr = 64'h1002;
`else
        addr = 64'h1000;
`endif
        wdata = 64'hAABBCCDD;
        @(negedge clk);
        we32 = 1'b0;
`ifdef STORE_MISALIGNED_SPLIT_EN
        mem_ready = 1'b1;
        @(negedge clk);
        mem_ready = 1'b0;
        chk("pre_rst_beat1_addr", o_addr, 64'h1004);
`endif
        chk("pre_rst_valid", {63'h0, o_valid}, 64'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_stall", {63'h0, o_stall}, 64'h0);
        chk("mid_rst_valid", {63'h0, o_valid}, 64'h0);
        chk("mid_rst_be", o_be, 64'h0);
        chk("mid_rst_addr", o_addr, 64'h0);
        chk("mid_rst_wdata", o_wd, 64'h0);
        chk("mid_rst_pulses", {62'h0, o_mis, o_ill}, 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        mem_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("post_rst_valid", {63'h0, o_valid}, 64'h0);
        end
        mem_ready = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
